// File: rtl/board_pkg.sv
// board_pkg: piece/colour encodings, back-rank layout and width helpers
// shared by the board store and its undo history.
package board_pkg;
  localparam int PIECE_W_DEF = 4;
  localparam logic WHITE = 1'b0;
  localparam logic BLACK = 1'b1;
  localparam logic [2:0] NONE   = 3'd0;
  localparam logic [2:0] PAWN   = 3'd1;
  localparam logic [2:0] KNIGHT = 3'd2;
  localparam logic [2:0] BISHOP = 3'd3;
  localparam logic [2:0] ROOK   = 3'd4;
  localparam logic [2:0] QUEEN  = 3'd5;
  localparam logic [2:0] KING   = 3'd6;

  function automatic logic [2:0] back_rank(input int c);
    case (c % 8)
      0, 7:    return ROOK;
      1, 6:    return KNIGHT;
      2, 5:    return BISHOP;
      3:       return QUEEN;
      default: return KING;
    endcase
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/undo_stack.sv
// undo_stack: circular LIFO of move records; a push when full silently
// overwrites the oldest entry while the count stays saturated.
module undo_stack import board_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int EW = 20,
  localparam int CW = clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [EW-1:0] din_i,
  output logic [EW-1:0] top_o,
  output logic [CW-1:0] count_o
);
  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] ptr_q, ptr_inc, ptr_dec;
  logic [CW-1:0] count_q;

  assign ptr_inc = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
  assign ptr_dec = (ptr_q == '0) ? PW'(DEPTH - 1) : ptr_q - 1'b1;
  assign top_o   = mem_q[ptr_dec];
  assign count_o = count_q;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else if (clr_i) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else if (push_i) begin
      ptr_q   <= ptr_inc;
      count_q <= (count_q == CW'(DEPTH)) ? count_q : count_q + 1'b1;
    end else if (pop_i) begin
      ptr_q   <= ptr_dec;
      count_q <= count_q - 1'b1;
    end

  always_ff @(posedge clk_i)
    if (push_i) mem_q[ptr_q] <= din_i;
endmodule

// File: rtl/board_store.sv
// board_store: ROWS x COLS board registers with a row-sweep initial layout,
// atomic valid/ready moves and a bounded undo history.
module board_store import board_pkg::*; #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int PIECE_W = PIECE_W_DEF,
  parameter int UNDO_DEPTH = 8,
  localparam int N = ROWS * COLS,
  localparam int AW = clog2(N),
  localparam int CW = clog2(UNDO_DEPTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 init_req_i,
  input  logic                 move_valid_i,
  output logic                 move_ready_o,
  input  logic [AW-1:0]        move_src_i,
  input  logic [AW-1:0]        move_dst_i,
  input  logic [PIECE_W-1:0]   move_piece_i,
  input  logic                 undo_req_i,
  output logic                 busy_o,
  output logic [N*PIECE_W-1:0] board_o,
  output logic [PIECE_W-1:0]   captured_o,
  output logic [CW-1:0]        undo_count_o,
  output logic                 err_o
);
  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_IDLE = 1'b1;
  localparam int RW = clog2(ROWS);
  localparam int EW = 2 * AW + 2 * PIECE_W;

  logic [0:0]         state_q, state_d;
  logic [RW-1:0]      row_q, row_d;
  logic [PIECE_W-1:0] board_q [N];
  logic [PIECE_W-1:0] captured_q;
  logic               err_q, err_d;
  logic               bad, push, pop, idle_cmd;
  logic [AW-1:0]      h_src, h_dst;
  logic [PIECE_W-1:0] h_osrc, h_odst;
  logic [CW-1:0]      count;

  function automatic logic [PIECE_W-1:0] init_sq(input int r, input int c);
    logic [PIECE_W-1:0] v;
    v = '0;
    v[PIECE_W-1] = (r < 2) ? BLACK : WHITE;
    v[2:0] = (r == 0 || r == ROWS - 1) ? back_rank(c) :
             (r == 1 || r == ROWS - 2) ? PAWN : NONE;
    return v;
  endfunction

  assign idle_cmd     = (state_q == S_IDLE) & ~init_req_i;
  assign move_ready_o = idle_cmd & ~undo_req_i;
  assign busy_o       = (state_q == S_INIT);
  assign captured_o   = captured_q;
  assign undo_count_o = count;
  assign err_o        = err_q;
  assign bad  = (move_src_i == move_dst_i) | (int'(move_src_i) >= N) | (int'(move_dst_i) >= N);
  assign push = move_valid_i & move_ready_o & ~bad;
  assign pop  = idle_cmd & undo_req_i & (count != '0);
  assign err_d = (move_valid_i & move_ready_o & bad) | (idle_cmd & undo_req_i & (count == '0));
  assign state_d = init_req_i ? S_INIT :
                   (state_q == S_INIT && row_q == RW'(ROWS - 1)) ? S_IDLE : state_q;
  assign row_d = init_req_i ? '0 : (state_q == S_INIT) ? row_q + 1'b1 : row_q;

  always_comb
    for (int n = 0; n < N; n++) board_o[n*PIECE_W +: PIECE_W] = board_q[n];

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      for (int n = 0; n < N; n++) board_q[n] <= '0;
      state_q    <= S_INIT;
      row_q      <= '0;
      captured_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      err_q   <= err_d;
      if (init_req_i)
        captured_q <= '0;
      else if (state_q == S_INIT)
        for (int c = 0; c < COLS; c++) board_q[AW'(int'(row_q) * COLS + c)] <= init_sq(int'(row_q), c);
      else if (pop) begin
        board_q[h_src] <= h_osrc;
        board_q[h_dst] <= h_odst;
        captured_q     <= '0;
      end else if (push) begin
        board_q[move_src_i] <= '0;
        board_q[move_dst_i] <= move_piece_i;
        captured_q          <= board_q[move_dst_i];
      end
    end

  undo_stack #(.DEPTH(UNDO_DEPTH), .EW(EW)) u_undo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (init_req_i),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ({move_src_i, move_dst_i, board_q[move_src_i], board_q[move_dst_i]}),
    .top_o   ({h_src, h_dst, h_osrc, h_odst}),
    .count_o (count)
  );
endmodule

// File: tb/tb_board_store.sv
// tb_board_store: directed and random stimulus against a square-array,
// history-queue model of the 8x8 board store.
module tb_board_store;
  localparam int N = 64;
  logic clk = 0, rst_n = 1, init_req = 0, mv_valid = 0, undo_req = 0;
  logic [5:0] mv_src = 0, mv_dst = 0;
  logic [3:0] mv_piece = 0;
  logic mv_ready, busy, err;
  logic [N*4-1:0] board;
  logic [3:0] captured, ucount;
  int checks = 0, errors = 0;

  typedef struct { int s; int d; logic [3:0] os; logic [3:0] od; } hent_t;
  hent_t hist[$];
  logic [3:0] mb [N];
  logic [3:0] m_cap;
  bit m_busy, m_err;
  int m_row;
  int pat [8] = '{4, 2, 3, 5, 6, 3, 2, 4};

  always #5 clk = ~clk;

  board_store dut (
    .clk_i(clk), .rst_ni(rst_n), .init_req_i(init_req), .move_valid_i(mv_valid),
    .move_ready_o(mv_ready), .move_src_i(mv_src), .move_dst_i(mv_dst),
    .move_piece_i(mv_piece), .undo_req_i(undo_req), .busy_o(busy), .board_o(board),
    .captured_o(captured), .undo_count_o(ucount), .err_o(err)
  );

  task automatic chk(string tag, logic [255:0] got, logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] lay(int r, int c);
    if (r == 0) return 4'(8 + pat[c % 8]);
    if (r == 1) return 4'd9;
    if (r == 6) return 4'd1;
    if (r == 7) return 4'(pat[c % 8]);
    return 4'd0;
  endfunction

  function automatic logic [255:0] mflat();
    logic [255:0] f;
    for (int n = 0; n < N; n++) f[n*4 +: 4] = mb[n];
    return f;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < N; n++) mb[n] = 4'd0;
    m_cap = 0; m_busy = 1; m_row = 0; m_err = 0;
    hist.delete();
  endtask

  task automatic step(bit v, int s, int d, int p, bit u, bit i);
    hent_t e;
    mv_valid = v; mv_src = 6'(s); mv_dst = 6'(d); mv_piece = 4'(p); undo_req = u; init_req = i;
    #1 chk("ready", mv_ready, !m_busy && !i && !u);
    @(posedge clk);
    m_err = 0;
    if (i) begin
      m_busy = 1; m_row = 0; m_cap = 0; hist.delete();
    end else if (m_busy) begin
      for (int c = 0; c < 8; c++) mb[m_row*8 + c] = lay(m_row, c);
      m_row++;
      if (m_row == 8) m_busy = 0;
    end else if (u) begin
      if (hist.size() == 0) m_err = 1;
      else begin
        e = hist.pop_back();
        mb[e.s] = e.os; mb[e.d] = e.od; m_cap = 0;
      end
    end else if (v) begin
      if (s == d) m_err = 1;
      else begin
        hist.push_back('{s, d, mb[s], mb[d]});
        if (hist.size() > 8) void'(hist.pop_front());
        m_cap = mb[d]; mb[s] = 4'd0; mb[d] = 4'(p);
      end
    end
    @(negedge clk);
    chk("board", board, mflat());
    chk("captured", captured, m_cap);
    chk("undo_count", ucount, hist.size());
    chk("err", err, m_err);
    chk("busy", busy, m_busy);
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int r, s, d;
    #2 rst_n = 0;
    #1;
    chk("rst_board", board, 0);
    chk("rst_busy", busy, 1);
    chk("rst_ready", mv_ready, 0);
    chk("rst_count", ucount, 0);
    chk("rst_err", err, 0);
    chk("rst_cap", captured, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    idle(7);
    chk("busy_7", busy, 1);
    idle(1);
    chk("busy_8", busy, 0);
    chk("sq0", board[3:0], 4'b1100);
    chk("sq4", board[19:16], 4'b1110);
    chk("sq60", board[243:240], 4'b0110);
    chk("sq63", board[255:252], 4'b0100);
    chk("mid_rows", board[191:64], 0);
    step(1, 52, 36, 1, 0, 0);
    chk("sq36", board[147:144], 4'b0001);
    chk("sq52", board[211:208], 4'b0000);
    step(1, 36, 12, 1, 0, 0);
    chk("cap_1001", captured, 4'b1001);
    step(0, 0, 0, 0, 1, 0);
    chk("undo_sq12", board[51:48], 4'b1001);
    chk("undo_sq36", board[147:144], 4'b0001);
    step(0, 0, 0, 0, 1, 0);
    chk("undo_cnt0", ucount, 0);
    for (int k = 0; k < 10; k++) begin
      s = $urandom_range(0, 63);
      d = (s + 1 + $urandom_range(0, 62)) % 64;
      step(1, s, d, $urandom_range(0, 15), 0, 0);
    end
    chk("sat", ucount, 8);
    for (int k = 0; k < 9; k++) step(0, 0, 0, 0, 1, 0);
    chk("undo9_err", err, 1);
    step(1, 8, 40, 9, 0, 0);
    step(1, 9, 41, 9, 1, 0);
    chk("both_cnt", ucount, 0);
    step(1, 10, 42, 9, 0, 0);
    step(0, 0, 0, 0, 1, 1);
    chk("init_cnt", ucount, 0);
    idle(8);
    step(1, 5, 5, 3, 0, 0);
    chk("same_err", err, 1);
    step(0, 0, 0, 0, 0, 1);
    idle(3);
    rst_n = 0;
    #1;
    chk("async_board", board, 0);
    chk("async_busy", busy, 1);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    idle(8);
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 99);
      s = $urandom_range(0, 63);
      d = ($urandom_range(0, 9) == 0) ? s : $urandom_range(0, 63);
      step(r < 60 || r >= 95, s, d, $urandom_range(0, 15), (r >= 60 && r < 85) || r >= 95, r == 97);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
